glorb_ctrl: RTL and testbench

- Multi-cycle sequencer for the 8-bit core.
- Fetches an instruction over a request/ack handshake and presents it and the PC to the ALU.
- Drives register-file read/write addresses and write enable, and computes the next PC from the ALU result.
- Sits between instruction memory, register file and ALU; one instruction in flight at a time.

---
 rtl/glorb_ctrl_pkg.sv | 31 +++
 rtl/glorb_ctrl_nextpc.sv | 38 +++
 rtl/glorb_ctrl.sv | 123 ++++++++++++
 tb/tb_glorb_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glorb_ctrl_pkg.sv
// Shared encodings for the glorb 8-bit core sequencer: opcode/funct fields,
// controller state encoding and small instruction-field helpers.
package glorb_ctrl_pkg;

    localparam logic OP_R = 1'b0;
    localparam logic OP_B = 1'b1;

    localparam logic [1:0] R_ADD = 2'd0;
    localparam logic [1:0] R_AND = 2'd1;
    localparam logic [1:0] R_OR  = 2'd2;
    localparam logic [1:0] R_XOR = 2'd3;

    localparam logic B_BEQ = 1'b0;
    localparam logic B_BLT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic op_of(input logic [7:0] ins);
        return ins[0];
    endfunction

    function automatic logic bfunct_of(input logic [7:0] ins);
        return ins[1];
    endfunction

endpackage

// File: rtl/glorb_ctrl_nextpc.sv
// Combinational next-PC selection for one executing instruction.
// The ALU result is truncated to the PC width before it is used.
module glorb_ctrl_nextpc
    import glorb_ctrl_pkg::*;
#(
    parameter int IW  = 8,
    parameter int IMW = 4,
    parameter int DW  = 8
) (
    input  logic [IW-1:0]  instr,
    input  logic [IMW-1:0] pc,
    input  logic [DW-1:0]  rs1_data,
    input  logic [DW-1:0]  rd_data,
    input  logic [DW-1:0]  alu_out,
    output logic [IMW-1:0] next_pc
);

    logic [IMW-1:0] pc_inc;
    logic [IMW-1:0] alu_trunc;
    logic           unused_bits;

    assign pc_inc      = pc + IMW'(1);
    assign alu_trunc   = alu_out[IMW-1:0];
    assign unused_bits = ^{instr[IW-1:2], alu_out[DW-1:IMW]};

    // BLT relies on the ALU to supply either the immediate or 1 as the offset.
    always_comb begin
        next_pc = pc_inc;
        if (op_of(instr[7:0]) == OP_B) begin
            if (bfunct_of(instr[7:0]) == B_BEQ) begin
                next_pc = (rs1_data == rd_data) ? alu_trunc : pc_inc;
            end else begin
                next_pc = pc + alu_trunc;
            end
        end
    end

endmodule

// File: rtl/glorb_ctrl.sv
// Multi-cycle fetch/execute sequencer for the glorb 8-bit core.
// Optional HALT-on-self-branch detection is enabled by GLORB_CTRL_HALT_DETECT_EN.
module glorb_ctrl
    import glorb_ctrl_pkg::*;
#(
    parameter int IW  = 8,
    parameter int IMW = 4,
    parameter int DW  = 8,
    parameter int RCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic           imem_req,
    output logic [IMW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [IW-1:0]  imem_data,
    output logic [IW-1:0]  instr,
    output logic [IMW-1:0] pc,
    output logic [1:0]     rs1_addr,
    output logic [1:0]     rd_addr,
    input  logic [DW-1:0]  rs1_data,
    input  logic [DW-1:0]  rd_data,
    input  logic [DW-1:0]  alu_out,
    output logic           rf_we,
    output logic [1:0]     rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic           busy,
    output logic           halted,
    output logic [RCW-1:0] retired
);

    state_t         state_reg, state_next;
    logic [IMW-1:0] pc_reg, pc_next;
    logic [IW-1:0]  instr_reg, instr_next;
    logic [RCW-1:0] retired_reg, retired_next;
    logic [IMW-1:0] nextpc_val;

    glorb_ctrl_nextpc #(
        .IW  (IW),
        .IMW (IMW),
        .DW  (DW)
    ) u_nextpc (
        .instr    (instr_reg),
        .pc       (pc_reg),
        .rs1_data (rs1_data),
        .rd_data  (rd_data),
        .alu_out  (alu_out),
        .next_pc  (nextpc_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            instr_reg   <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            retired_reg <= retired_next;
        end
    end

    // An ack is only honoured in FETCH, so a late ack after reset is dropped.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        retired_next = retired_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_data;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_next      = nextpc_val;
                retired_next = retired_reg + RCW'(1);
`ifdef GLORB_CTRL_HALT_DETECT_EN
                if (nextpc_val == pc_reg) state_next = ST_HALT;
                else                      state_next = run ? ST_FETCH : ST_IDLE;
`else
                state_next = run ? ST_FETCH : ST_IDLE;
`endif
            end
            ST_HALT: begin
`ifdef GLORB_CTRL_HALT_DETECT_EN
                state_next = ST_HALT;
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state_reg == ST_FETCH);
        busy     = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);
        rf_we    = (state_reg == ST_EXEC) && (op_of(instr_reg[7:0]) == OP_R);
`ifdef GLORB_CTRL_HALT_DETECT_EN
        halted   = (state_reg == ST_HALT);
`else
        halted   = 1'b0;
`endif
    end

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign instr     = instr_reg;
    assign retired   = retired_reg;
    assign rs1_addr  = instr_reg[7:6];
    assign rd_addr   = instr_reg[5:4];
    assign rf_waddr  = instr_reg[5:4];
    assign rf_wdata  = alu_out;

endmodule

// File: tb/tb_glorb_ctrl.sv
// Scoreboard bench for glorb_ctrl: directed programs push expected EXEC records,
// a monitor pops and compares one record per EXEC cycle.
module tb_glorb_ctrl;
    import glorb_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic [3:0] pc;
    logic [1:0] rs1_addr, rd_addr;
    logic [7:0] rs1_data = 8'h00;
    logic [7:0] rd_data  = 8'h00;
    logic [7:0] alu_out  = 8'h00;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       busy, halted;
    logic [7:0] retired;

    glorb_ctrl dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rd_data(rd_data), .alu_out(alu_out),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Instruction memory model with an optional slow address.
    logic [7:0] mem [16];
    int   slow_addr = -1;
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    logic force_ack = 1'b0;

    always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    assign imem_ack  = force_ack | (imem_req && ((int'(imem_addr) != slow_addr) || (wait_cnt >= ack_delay)));
    assign imem_data = mem[imem_addr];

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] ins;
        logic       we;
        logic [1:0] waddr;
        logic [7:0] wdata;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   req5   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [3:0] p, input logic [7:0] ins, input logic [7:0] a);
        rec_t r;
        r.pc    = p;
        r.ins   = ins;
        r.we    = (ins[0] == OP_R);
        r.waddr = ins[5:4];
        r.wdata = a;
        return r;
    endfunction

    // Monitor: an EXEC cycle is busy without a fetch request.
    rec_t mon_exp, mon_act;
    always @(negedge clk) begin
        if (!rst && imem_req && imem_addr == 4'd5) req5++;
        if (!rst && busy && !imem_req) begin
            mon_act = '{pc, instr, rf_we, rf_waddr, rf_wdata};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exec: got pc=%0h instr=%0h with no expected record", pc, instr);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("exec_record", 32'(mon_act), 32'(mon_exp));
                $display("exec pc=%0h instr=%02h we=%0b waddr=%0d wdata=%02h", pc, instr, rf_we, rf_waddr, rf_wdata);
            end
        end else if (rf_we) begin
            checks++;
            errors++;
            $display("FAIL rf_we_outside_exec: got rf_we=1 required 0 (busy=%0b req=%0b)", busy, imem_req);
        end
    end

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d records pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_prog(input bit drop_run);
        run = 1'b1;
        wait_drain();
        if (drop_run) run = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_mem(8'h00);

        // Reset state
        do_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_retired", retired, 0);
        settle();
        chk("idle_no_run_busy", busy, 0);

        // Single ADD r0,r0 with zero-wait memory
        alu_out = 8'h5A;
        exp_q.push_back(mk(4'd0, 8'h00, 8'h5A));
        run = 1'b1;
        @(negedge clk);
        #1;
        chk("t1_req_cycle1", {imem_req, imem_addr}, {1'b1, 4'd0});
        run_prog(1);
        chk("t1_pc", pc, 1);
        chk("t1_retired", retired, 1);
        chk("t1_busy", busy, 0);

        // Ack delayed 3 cycles at pc=5
        do_reset();
        alu_out   = 8'h21;
        slow_addr = 5;
        ack_delay = 3;
        req5      = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(4'(i), 8'h00, 8'h21));
        run_prog(1);
        chk("t2_req5_cycles", req5, 4);
        chk("t2_pc", pc, 6);
        chk("t2_retired", retired, 6);
        slow_addr = -1;

        // BEQ at pc=2, imm=3, taken and not taken
        for (int k = 0; k < 2; k++) begin
            do_reset();
            fill_mem(8'h00);
            mem[2]   = 8'h0D;
            rs1_data = 8'h11;
            rd_data  = (k == 0) ? 8'h11 : 8'h12;
            alu_out  = 8'h05;
            exp_q.push_back(mk(4'd0, 8'h00, 8'h05));
            exp_q.push_back(mk(4'd1, 8'h00, 8'h05));
            exp_q.push_back(mk(4'd2, 8'h0D, 8'h05));
            run_prog(1);
            chk(k == 0 ? "t3_beq_taken_pc" : "t3_beq_not_taken_pc", pc, (k == 0) ? 5 : 3);
        end

        // 256 instructions: XOR at pc=15 wraps the PC, retired wraps to 0
        do_reset();
        fill_mem(8'h00);
        mem[15] = {2'b00, 2'b00, R_XOR, 2'b00};
        alu_out = 8'h3C;
        for (int i = 0; i < 256; i++) exp_q.push_back(mk(4'(i % 16), (i % 16 == 15) ? 8'h0C : 8'h00, 8'h3C));
        run_prog(1);
        chk("t4_pc_wrap", pc, 0);
        chk("t4_retired_wrap", retired, 0);

        // run dropped during FETCH: instruction still completes once
        do_reset();
        fill_mem(8'h00);
        slow_addr = 0;
        ack_delay = 3;
        alu_out   = 8'h77;
        exp_q.push_back(mk(4'd0, 8'h00, 8'h77));
        run = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        run = 1'b0;
        wait_drain();
        settle();
        chk("t5_busy", busy, 0);
        chk("t5_pc", pc, 1);
        chk("t5_retired", retired, 1);

        // rst mid-FETCH, then a stray ack
        do_reset();
        run = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        chk("t6_in_fetch", imem_req, 1);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_pc", pc, 0);
        mem[0]    = 8'h4C;
        force_ack = 1'b1;
        @(negedge clk);
        #1;
        force_ack = 1'b0;
        settle();
        chk("t6_stray_busy", busy, 0);
        chk("t6_stray_instr", instr, 0);
        chk("t6_stray_retired", retired, 0);
        slow_addr = -1;

        // Branch-to-self at pc=7
        do_reset();
        fill_mem(8'h00);
        mem[7]   = 8'h01;
        rs1_data = 8'h11;
        rd_data  = 8'h11;
        alu_out  = 8'h07;
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(4'(i), 8'h00, 8'h07));
`ifdef GLORB_CTRL_HALT_DETECT_EN
        exp_q.push_back(mk(4'd7, 8'h01, 8'h07));
        run_prog(0);
        settle();
        chk("t7_halted", halted, 1);
        chk("t7_busy", busy, 0);
        chk("t7_req", imem_req, 0);
        chk("t7_pc", pc, 7);
        chk("t7_retired", retired, 8);
        run = 1'b0;
`else
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(4'd7, 8'h01, 8'h07));
        run_prog(1);
        chk("t7_halted", halted, 0);
        chk("t7_pc", pc, 7);
        chk("t7_retired", retired, 10);
        chk("t7_busy", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
